// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe_if
//  Description : Request/response bundle between operand fetch, alu_pipe and
//                writeback (valid/ready on both sides plus status flags).
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_pipe_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             negative;
    logic             zero;
    logic             equal;
    logic             greater;
    logic             less;
    logic             busy;

    modport master (
        output in_valid, opcode, a, b, out_ready,
        input  in_ready, out_valid, result, overflow, negative, zero,
               equal, greater, less, busy
    );

    modport slave (
        input  in_valid, opcode, a, b, out_ready,
        output in_ready, out_valid, result, overflow, negative, zero,
               equal, greater, less, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Registered, handshaked ALU with iterative shift-add multiply.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_pipe_if.slave    bus
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_mul  = 1'b1;

    localparam logic [3:0] c_op_load = 4'd0;
    localparam logic [3:0] c_op_add  = 4'd1;
    localparam logic [3:0] c_op_sub  = 4'd2;
    localparam logic [3:0] c_op_and  = 4'd3;
    localparam logic [3:0] c_op_xor  = 4'd4;
    localparam logic [3:0] c_op_not  = 4'd5;
    localparam logic [3:0] c_op_inc  = 4'd6;
    localparam logic [3:0] c_op_mul  = 4'd7;

    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_int_max = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [CNT_W-1:0] c_last    = CNT_W'(WIDTH - 1);

    logic [0:0]         state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   mcand_q,     mcand_d;
    logic [2*WIDTH-1:0] prod_q,      prod_d;
    logic [2:0]         cmp_q,       cmp_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q,    result_d;
    logic               ovf_q,       ovf_d;
    logic               neg_q,       neg_d;
    logic               zero_q,      zero_d;
    logic               eq_q,        eq_d;
    logic               gt_q,        gt_d;
    logic               lt_q,        lt_d;

    logic               in_ready;
    logic               accept;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic               load_en;
    logic [WIDTH-1:0]   load_res;
    logic               load_ovf;
    logic [2:0]         load_cmp;

    assign in_ready      = (state_q == c_st_idle) && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = ovf_q;
    assign bus.negative  = neg_q;
    assign bus.zero      = zero_q;
    assign bus.equal     = eq_q;
    assign bus.greater   = gt_q;
    assign bus.less      = lt_q;
    assign bus.busy      = (state_q == c_st_mul);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.opcode)
            c_op_load: alu_res = bus.a;
            c_op_add: begin
                alu_res = bus.a + bus.b;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            c_op_sub: begin
                alu_res = bus.a - bus.b;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            c_op_and:  alu_res = bus.a & bus.b;
            c_op_xor:  alu_res = bus.a ^ bus.b;
            c_op_not:  alu_res = ~bus.a;
            c_op_inc: begin
                alu_res = bus.a + c_one;
                alu_ovf = (bus.a == c_int_max);
            end
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // Right-shifting product register: upper half accumulates, lower half
    // starts as the multiplier and is consumed LSB first.
    assign addend   = prod_q[0] ? mcand_q : {WIDTH{1'b0}};
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        cmp_d       = cmp_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        result_d    = result_q;
        ovf_d       = ovf_q;
        neg_d       = neg_q;
        zero_d      = zero_q;
        eq_d        = eq_q;
        gt_d        = gt_q;
        lt_d        = lt_q;
        load_en     = 1'b0;
        load_res    = '0;
        load_ovf    = 1'b0;
        load_cmp    = '0;

        if (state_q == c_st_idle) begin
            if (accept) begin
                if (bus.opcode == c_op_mul) begin
                    state_d = c_st_mul;
                    cnt_d   = '0;
                    mcand_d = bus.a;
                    prod_d  = {{WIDTH{1'b0}}, bus.b};
                    cmp_d   = {bus.a == bus.b, bus.a > bus.b, bus.a < bus.b};
                end else begin
                    load_en  = 1'b1;
                    load_res = alu_res;
                    load_ovf = alu_ovf;
                    load_cmp = {bus.a == bus.b, bus.a > bus.b, bus.a < bus.b};
                end
            end
        end else begin
            prod_d = mul_next;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == c_last) begin
                // Output register is necessarily empty here: MUL was only
                // accepted when it was free and nothing loads while busy.
                state_d  = c_st_idle;
                cnt_d    = '0;
                load_en  = 1'b1;
                load_res = mul_next[WIDTH-1:0];
                load_ovf = |mul_next[2*WIDTH-1:WIDTH];
                load_cmp = cmp_q;
            end
        end

        if (load_en) begin
            out_valid_d = 1'b1;
            result_d    = load_res;
            ovf_d       = load_ovf;
            neg_d       = load_res[WIDTH-1];
            zero_d      = (load_res == '0);
            eq_d        = load_cmp[2];
            gt_d        = load_cmp[1];
            lt_d        = load_cmp[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_st_idle;
            cnt_q       <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
            cmp_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
            zero_q      <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
            cmp_q       <= cmp_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            neg_q       <= neg_d;
            zero_q      <= zero_d;
            eq_q        <= eq_d;
            gt_q        <= gt_d;
            lt_q        <= lt_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the datapath's combinational 64-bit ALU.
- Registers every result and its status flags, and adds an iterative unsigned multiply.
- Sits between the decode/operand-fetch stage and writeback.
- Uses valid/ready on both sides, so a multi-cycle MUL stalls upstream without a global stall signal.

Parameters:
- WIDTH, 64, operand/result width in bits (>=8).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width (derived, do not override).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  block can accept a request this cycle
- opcode  in  4  0 LOAD, 1 ADD, 2 SUB, 3 AND, 4 XOR, 5 NOT, 6 INC, 7 MUL, 8-15 reserved
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  operation result
- overflow, negative, zero, equal, greater, less  out  1 each  registered status flags
- busy  out  1  MUL iteration in progress

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0; result=0; all flags=0; busy=0; counter=0.
  - Reset asserted mid-MUL discards the operation; nothing is output after release.
- States:
  - IDLE: may accept.
  - MUL_BUSY: iterating.
  - Output register is separate from state: out_valid plus result/flags.
- Acceptance: handshake fires when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Single-cycle ops (0-6): on the accept edge, result and flags are loaded and out_valid=1. Latency 1. Back-to-back accept every cycle while out_ready=1.
- Op semantics:
  - LOAD: a. ADD: a+b. SUB: a-b. AND: a&b. XOR: a^b. NOT: ~a. INC: a+1.
  - All results wrap modulo 2^WIDTH.
  - Reserved opcodes give result 0, all flags computed from that result/operands, overflow=0.
- MUL:
  - Accept edge: latch a (multiplicand) and b (multiplier), clear the accumulator, go to MUL_BUSY, busy=1.
  - Each cycle processes one multiplier bit, LSB first, shift-add.
  - After WIDTH iterations (the WIDTH-th edge after accept): result = low WIDTH bits of a*b, out_valid=1, state=IDLE, busy=0.
  - Latency WIDTH edges. Operands are captured, so input changes during BUSY are ignored.
- Output hold: while out_valid && !out_ready, result and flags hold stable. A new result may overwrite only on a cycle where out_ready=1.
- Completion edge: out_valid clears on an out_ready edge unless a new result loads the same edge; a new result on that edge keeps out_valid=1 with the new data.
- Flags (registered with result, from the accepted operands):
  - equal = a==b; greater = a>b (unsigned); less = a<b (unsigned).
  - zero = result==0; negative = result[WIDTH-1].
- overflow, signed two's complement:
  - ADD: a,b same sign and result sign differs.
  - SUB: a,b signs differ and result sign differs from a.
  - INC: a == {0,1...1}.
  - MUL: upper WIDTH bits of the full 2*WIDTH product nonzero (unsigned).
  - All other ops: 0.
- Simultaneous events: out_ready and in_valid in the same cycle with out_valid=1 in IDLE means consume plus accept; no bubble, no lost result.

Test Plan:
- Reset release, idle, no request -> out_valid=0, result=0, all flags 0, in_ready=1 after the first edge.
- ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> next cycle result=0x8000_0000_0000_0000, overflow=1, negative=1, zero=0, greater=1.
- SUB a=b=0x1234 -> result=0, zero=1, equal=1, overflow=0. INC a=0xFFFF_FFFF_FFFF_FFFF -> result=0, zero=1, overflow=0.
- MUL a=3, b=5, out_ready=1:
  - in_ready=0 and busy=1 for 64 cycles; result=15 on edge 64, overflow=0.
  - MUL a=2^63, b=2 -> result=0, overflow=1, zero=1.
- Backpressure: four single-cycle ops in consecutive cycles with out_ready=0 after the first -> in_ready drops; first result holds stable; releasing out_ready drains the rest in order, one per cycle.
- rst_n pulsed low at iteration 30 of a MUL -> out_valid=0 and busy=0 immediately; after release, a new ADD 2+2 returns 4 with latency 1.
